// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit 7-segment driver with a per-frame input snapshot,
// leading-zero blanking, a dash for codes A-F and configurable polarity.
module seven_seg_scanner #(
  parameter int unsigned N_DIGITS         = 4,
  parameter int unsigned SCAN_DIV         = 50000,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     anodes,
  output logic                    frame_start
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0]       PMAX    = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IMAX    = IW'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                DP_INV  = 1'(SEG_ACTIVE_LOW);
  localparam logic [N_DIGITS-1:0] AN_INV  = ANODE_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   sh_dig_q, sh_dig_d;
  logic [N_DIGITS-1:0]     sh_dp_q, sh_dp_d;
  logic                    sh_blz_q, sh_blz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    fs_q, fs_d;

  logic                    tick_c;
  logic [3:0]              cur_dig_c;
  logic                    cur_dp_c;
  logic [N_DIGITS:0]       zero_above_c;
  logic                    blank_c;
  logic [N_DIGITS-1:0]     an_oh_c;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Prescaler, digit index and frame snapshot
  always_comb begin
    tick_c   = (presc_q == PMAX);
    presc_d  = tick_c ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    sh_dig_d = sh_dig_q;
    sh_dp_d  = sh_dp_q;
    sh_blz_d = sh_blz_q;
    fs_d     = 1'b0;
    if (tick_c) begin
      if (idx_q == IMAX) begin
        idx_d    = '0;
        sh_dig_d = digits;
        sh_dp_d  = dp_in;
        sh_blz_d = blank_lz;
        fs_d     = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Decode of the digit currently selected by idx_q, including blanking
  always_comb begin
    cur_dig_c = 4'(sh_dig_q >> {idx_q, 2'b00});
    cur_dp_c  = 1'(sh_dp_q >> idx_q);
    an_oh_c   = N_DIGITS'(1) << idx_q;
    zero_above_c[N_DIGITS] = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above_c[i] = zero_above_c[i+1] & (sh_dig_q[4*i +: 4] == 4'd0);
    end
    blank_c = sh_blz_q && (idx_q != '0) && zero_above_c[idx_q];

    seg_d = SEG_INV;
    dp_d  = DP_INV;
    an_d  = AN_INV;
    if (enable) begin
      seg_d = (blank_c ? 7'b0000000 : bcd_to_seg(cur_dig_c)) ^ SEG_INV;
      dp_d  = cur_dp_c ^ DP_INV;
      an_d  = an_oh_c ^ AN_INV;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= IMAX;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_blz_q <= 1'b0;
      seg_q    <= SEG_INV;
      dp_q     <= DP_INV;
      an_q     <= AN_INV;
      fs_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_blz_q <= sh_blz_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
    end
  end

  assign segments    = seg_q;
  assign dp          = dp_q;
  assign anodes      = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: three configurations driven in parallel and
// checked every cycle against an arithmetic model of the scan timeline.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [3:0] an_a, an_b;
  logic       an_c;
  logic       fs_a, fs_b, fs_c;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state per configuration: 0 = A, 1 = B, 2 = C
  int         cnt  [3];
  logic [15:0] sd  [3];
  logic [3:0] sdp  [3];
  logic       sblz [3];
  logic [6:0] eseg [3];
  logic       edp  [3];
  logic [3:0] ean  [3];
  logic       efs  [3];

  always #5 clk = ~clk;

  seven_seg_scanner #(.N_DIGITS(4), .SCAN_DIV(4), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .segments(seg_a), .dp(dp_a), .anodes(an_a), .frame_start(fs_a));

  seven_seg_scanner #(.N_DIGITS(4), .SCAN_DIV(3), .ANODE_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .segments(seg_b), .dp(dp_b), .anodes(an_b), .frame_start(fs_b));

  seven_seg_scanner #(.N_DIGITS(1), .SCAN_DIV(1), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits[3:0]), .dp_in(dp_in[0:0]),
    .blank_lz(blank_lz), .segments(seg_c), .dp(dp_c), .anodes(an_c), .frame_start(fs_c));

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tab [10];
    tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    if (v > 4'd9) return 7'b0000001;
    return tab[v];
  endfunction

  task automatic model_reset(input int d, input int n, input bit aal, input bit sal);
    cnt[d]  = 0;
    sd[d]   = '0;
    sdp[d]  = '0;
    sblz[d] = 1'b0;
    eseg[d] = sal ? 7'h7F : 7'h00;
    edp[d]  = sal;
    ean[d]  = aal ? ((n == 4) ? 4'hF : 4'h1) : 4'h0;
    efs[d]  = 1'b0;
  endtask

  // Edge number c after release shows the digit selected after c-1 edges;
  // idx starts at n-1 and advances once per div edges.
  task automatic model_edge(input int d, input int n, input int div, input bit aal, input bit sal);
    int idx, j;
    logic [6:0] s;
    logic p;
    logic [3:0] an, mask4;
    logic [15:0] maskd;
    bit blank;
    mask4 = (n == 4) ? 4'hF : 4'h1;
    maskd = (n == 4) ? 16'hFFFF : 16'h000F;
    cnt[d] = cnt[d] + 1;
    idx   = (n - 1 + (cnt[d] - 1) / div) % n;
    blank = sblz[d] && (idx > 0) && ((sd[d] >> (4 * idx)) == 16'h0);
    s     = blank ? 7'b0 : seg_of(4'(sd[d] >> (4 * idx)));
    p     = sdp[d][idx];
    an    = 4'(1 << idx);
    if (!enable) begin
      s  = 7'b0;
      p  = 1'b0;
      an = 4'b0;
    end
    eseg[d] = sal ? ~s : s;
    edp[d]  = sal ? ~p : p;
    ean[d]  = aal ? (~an & mask4) : an;
    j       = cnt[d] / div;
    efs[d]  = (cnt[d] % div == 0) && ((j - 1) % n == 0);
    if (efs[d]) begin
      sd[d]   = digits & maskd;
      sdp[d]  = dp_in & mask4;
      sblz[d] = blank_lz;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_seg", 16'(seg_a), 16'(eseg[0]));
    chk("a_dp",  16'(dp_a),  16'(edp[0]));
    chk("a_an",  16'(an_a),  16'(ean[0]));
    chk("a_fs",  16'(fs_a),  16'(efs[0]));
    chk("b_seg", 16'(seg_b), 16'(eseg[1]));
    chk("b_dp",  16'(dp_b),  16'(edp[1]));
    chk("b_an",  16'(an_b),  16'(ean[1]));
    chk("b_fs",  16'(fs_b),  16'(efs[1]));
    chk("c_seg", 16'(seg_c), 16'(eseg[2]));
    chk("c_dp",  16'(dp_c),  16'(edp[2]));
    chk("c_an",  16'(an_c),  16'(ean[2]));
    chk("c_fs",  16'(fs_c),  16'(efs[2]));
  endtask

  task automatic reset_models();
    model_reset(0, 4, 1'b1, 1'b0);
    model_reset(1, 4, 1'b0, 1'b1);
    model_reset(2, 1, 1'b1, 1'b0);
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      if (!reset) begin
        model_edge(0, 4, 4, 1'b1, 1'b0);
        model_edge(1, 4, 3, 1'b0, 1'b1);
        model_edge(2, 1, 1, 1'b1, 1'b0);
      end
      #1;
      check_all();
    end
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    digits   = 16'h1234;
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    reset_models();
    #1;
    check_all();
    cyc(2);
    reset = 1'b0;

    // First frame starts after SCAN_DIV edges; then digit 0 = '4'
    cyc(5);
    chk("t2_an0", 16'(an_a), 16'(4'b1110));
    chk("t2_seg0", 16'(seg_a), 16'(7'b0110011));
    cyc(7);
    // Digit 2 is showing: new inputs must not appear until the next frame
    digits = 16'h5678;
    cyc(4);
    chk("t3_seg2", 16'(seg_a), 16'(7'b1101101));
    cyc(20);

    // Leading-zero blanking
    blank_lz = 1'b1;
    digits   = 16'h0070;
    cyc(40);
    digits = 16'h0000;
    cyc(40);
    blank_lz = 1'b0;
    cyc(40);

    // Dash and decimal point
    digits = 16'hFA09;
    dp_in  = 4'b0100;
    cyc(40);

    // Enable toggled mid-digit
    cyc(2);
    enable = 1'b0;
    cyc(1);
    chk("t6_an_off", 16'(an_a), 16'(4'b1111));
    chk("t6_seg_off", 16'(seg_a), 16'(7'b0));
    cyc(9);
    enable = 1'b1;
    cyc(20);

    // Asynchronous reset mid-frame
    cyc(2);
    reset = 1'b1;
    #1;
    reset_models();
    chk("t1_an_rst", 16'(an_a), 16'(4'b1111));
    chk("t1_seg_rst", 16'(seg_a), 16'(7'b0));
    chk("t1_fs_rst", 16'(fs_a), 16'(1'b0));
    check_all();
    cyc(3);
    reset = 1'b0;
    cyc(3);
    chk("t1_fs_early", 16'(fs_a), 16'(1'b0));
    cyc(1);
    chk("t1_fs_div", 16'(fs_a), 16'(1'b1));

    // Randomized inputs
    for (int r = 0; r < 120; r++) begin
      digits   = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      if ($urandom_range(0, 3) == 0) digits[15:8] = 8'h00;
      enable   = ($urandom_range(0, 9) != 0);
      cyc($urandom_range(1, 6));
    end
    enable = 1'b1;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
